score_bcd_scan_display: RTL
===========================

// Module: score_bcd_scan_display
// PURPOSE
//  Parametrised score unit for the snake game: N-digit BCD score counter with per-event
//  increment value, saturation, high-score capture on death, and a time-multiplexed
//  common-anode 7-segment driver with leading-zero blanking. Sits between the game
//  FSM (status/add) and the board display pins; replaces the fixed 4-digit static scorer.
// PARAMETERS
//  DIGITS    4      number of BCD digits (1..8); score width = 4*DIGITS
//  SCAN_DIV  50000  clk cycles each digit is enabled (>=2)
//  BLANK_LZ  1      1 = blank leading zeros (digit 0 always lit); 0 = show all digits
// PORTS
//  clk       in   1          system clock
//  rst       in   1          asynchronous, active-low reset
//  status    in   2          game state: 2'b00 RESTART, 2'b11 DIE, 01/10 PLAYING
//  add       in   1          food-eaten level; one increment per rising edge
//  add_val   in   4          points per event, binary 0..15 (values >9 clamped to 9)
//  show_hi   in   1          1 = display hiscore, 0 = display score
//  score     out  4*DIGITS   current score, BCD, digit 0 in [3:0]
//  hiscore   out  4*DIGITS   best score since reset, BCD
//  new_high  out  1          one-cycle pulse when hiscore is updated
//  sat       out  1          score saturated at all-9s
//  seg       out  7          segments {g,f,e,d,c,b,a}, active-low
//  an        out  DIGITS     digit enables, active-low, one-hot-low
// BEHAVIOUR
//  Reset (rst=0, async): score=0, hiscore=0, new_high=0, sat=0, seg=7'h7F, an=all 1s,
//   scan counter=0, digit index=0, add_q=0, prev status=RESTART.
//  Edge detect: add_q<=add each cycle; event = add & ~add_q & status PLAYING.
//   Holding add high gives exactly one event; add high during RESTART/DIE is
//   registered in add_q, so no event fires on return to PLAYING while still high.
//  Increment: on event, score<=score+min(add_val,9) as BCD, ripple carry across all
//   digits in one cycle; visible on score the cycle after the event. add_val=0: no-op.
//   If the true sum exceeds 10^DIGITS-1, score<=all 9s and sat<=1; further events no-op.
//  RESTART: score<=0, sat<=0 every cycle; hiscore held; scan continues.
//  DIE: score frozen. On the first DIE cycle (prev status != DIE), if score>hiscore
//   (BCD compare, MS digit first) hiscore<=score and new_high=1 for exactly one cycle.
//   Equal score: no update, no pulse. Staying in DIE never re-triggers.
//  PLAYING->RESTART->PLAYING without DIE: no hiscore update.
//  Scan: cnt counts 0..SCAN_DIV-1 then wraps; on wrap idx<=(idx==DIGITS-1)?0:idx+1.
//   an and seg are registered from idx/value: an[idx]=0, others 1; updated one cycle
//   after idx changes. Displayed value = show_hi ? hiscore : score, sampled live.
//  Decode (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex);
//   non-BCD nibble -> 7'h7F (blank).
//  Blanking (BLANK_LZ=1): digit i>0 shows 7'h7F when digits DIGITS-1..i are all zero;
//   digit 0 always decoded (score 0 shows "0"). an still scans blanked digits.
//  Simultaneous: status change and add edge in same cycle -> new status governs;
//   event counted only if the new status is PLAYING.
//  Reset mid-scan or mid-increment: all state returns to reset values immediately.
// TESTING
//  1 Reset, PLAYING, 3 add pulses add_val=1 -> score=16'h0003, sat=0, new_high never.
//  2 add held high 100 cycles, add_val=5 -> exactly one event, score=16'h0005.
//  3 score=16'h0998, add_val=7 -> score=16'h1005 (two-digit carry) one cycle later.
//  4 score=16'h9995, add_val=9 -> score=16'h9999, sat=1; next event -> unchanged.
//  5 score=0042, DIE -> hiscore=0042, new_high 1 cycle; RESTART, score 0030, DIE ->
//    hiscore stays 0042, no pulse.
//  6 SCAN_DIV=4, score=16'h0007 -> an cycles 1110,1101,1011,0111 every 4 clk;
//    seg=78 on digit 0, 7F on digits 1-3; show_hi=1 shows hiscore digits.

Source files
------------

// File: rtl/score_bcd_scan_display.sv
// Snake-game score unit: N-digit BCD score with saturation and high-score capture.
// Also drives a time-multiplexed common-anode 7-segment display with leading-zero blanking.
module score_bcd_scan_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            status,
    input  logic                  add,
    input  logic [3:0]            add_val,
    input  logic                  show_hi,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   hiscore,
    output logic                  new_high,
    output logic                  sat,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] ST_RESTART = 2'b00;
    localparam logic [1:0] ST_DIE     = 2'b11;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    logic                add_q;
    logic [1:0]          status_q;
    logic [SW-1:0]       score_q, score_d;
    logic [SW-1:0]       hiscore_q, hiscore_d;
    logic                new_high_q, new_high_d;
    logic                sat_q, sat_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic                playing;
    logic                add_event;
    logic [3:0]          inc;
    logic [SW-1:0]       sum;
    logic                carry;
    logic [4:0]          dsum;
    logic [4:0]          dsum_adj;

    assign playing   = status[0] ^ status[1];
    assign add_event = add & ~add_q & playing;
    assign inc       = (add_val > 4'd9) ? 4'd9 : add_val;

    // Ripple BCD add of inc into digit 0; final carry means the true sum overflowed.
    always_comb begin
        sum      = '0;
        carry    = 1'b0;
        dsum     = '0;
        dsum_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dsum     = {1'b0, score_q[4*i +: 4]} + {1'b0, ((i == 0) ? inc : 4'd0)} + {4'b0, carry};
            dsum_adj = dsum - 5'd10;
            if (dsum > 5'd9) begin
                sum[4*i +: 4] = dsum_adj[3:0];
                carry         = 1'b1;
            end else begin
                sum[4*i +: 4] = dsum[3:0];
                carry         = 1'b0;
            end
        end
    end

    always_comb begin
        score_d = score_q;
        sat_d   = sat_q;
        if (status == ST_RESTART) begin
            score_d = '0;
            sat_d   = 1'b0;
        end else if (add_event && (inc != 4'd0)) begin
            if (carry) begin
                score_d = {DIGITS{4'h9}};
                sat_d   = 1'b1;
            end else begin
                score_d = sum;
            end
        end
    end

    // Packed BCD compares correctly as unsigned binary because digits are MS-first.
    always_comb begin
        hiscore_d  = hiscore_q;
        new_high_d = 1'b0;
        if ((status == ST_DIE) && (status_q != ST_DIE) && (score_q > hiscore_q)) begin
            hiscore_d  = score_q;
            new_high_d = 1'b1;
        end
    end

    logic                cnt_wrap;
    logic [SW-1:0]       disp;
    logic [SW-1:0]       upper;
    logic                blank;

    assign cnt_wrap = (cnt_q == CW'(SCAN_DIV - 1));
    assign disp     = show_hi ? hiscore_q : score_q;
    assign upper    = disp >> {idx_q, 2'b00};
    assign blank    = BLANK_LZ && (idx_q != '0) && (upper == '0);

    always_comb begin
        cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        an_d  = ~(DIGITS'(1) << idx_q);
        seg_d = blank ? 7'h7F : seg_decode(upper[3:0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_q      <= 1'b0;
            status_q   <= ST_RESTART;
            score_q    <= '0;
            hiscore_q  <= '0;
            new_high_q <= 1'b0;
            sat_q      <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            seg_q      <= 7'h7F;
            an_q       <= '1;
        end else begin
            add_q      <= add;
            status_q   <= status;
            score_q    <= score_d;
            hiscore_q  <= hiscore_d;
            new_high_q <= new_high_d;
            sat_q      <= sat_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign score    = score_q;
    assign hiscore  = hiscore_q;
    assign new_high = new_high_q;
    assign sat      = sat_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule
